// File: rtl/branch_predict_unit_if.sv
// Purpose : bundles the fetch-lookup and execute-resolve signals of the branch predictor.
// Latency : n/a (wires only).
// Backpres: none; all signals are single-cycle qualified by ex_valid.
// Ports   : if_pc/if_pred_taken (fetch lookup), ex_* (execute resolve inputs),
//           jump/mispredict/flush (registered resolve results),
//           stat_branches/stat_mispredicts only when BPU_STATS_EN is defined.
// Modports: master = pipeline side, slave = predictor side.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_instr;
  logic            ex_br_eq;
  logic            ex_br_lt;
  logic            ex_pred_taken;
  logic            jump;
  logic            mispredict;
  logic            flush;
`ifdef BPU_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_instr, ex_br_eq, ex_br_lt, ex_pred_taken,
    input  if_pred_taken, jump, mispredict, flush, stat_branches, stat_mispredicts
  );
  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_instr, ex_br_eq, ex_br_lt, ex_pred_taken,
    output if_pred_taken, jump, mispredict, flush, stat_branches, stat_mispredicts
  );
`else
  modport master (
    output if_pc, ex_valid, ex_pc, ex_instr, ex_br_eq, ex_br_lt, ex_pred_taken,
    input  if_pred_taken, jump, mispredict, flush
  );
  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_instr, ex_br_eq, ex_br_lt, ex_pred_taken,
    output if_pred_taken, jump, mispredict, flush
  );
`endif
endinterface

// File: rtl/branch_predict_unit.sv
// Purpose : 2-bit saturating-counter BHT predictor with RV32I branch/jump resolve.
// Latency : lookup combinational; jump/mispredict/flush one cycle after ex_valid.
// Backpres: none; every ex_valid cycle is resolved and trained unconditionally.
// Ports   : clk, rst (sync, active-high), bus (branch_predict_unit_if.slave).
// Options : define BPU_STATS_EN to add saturating branch/mispredict counters.
module branch_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_unit_if.slave  bus
);

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  logic [XLEN-1:0]  if_pc;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_instr;
  logic [4:0]       opcode;
  logic [2:0]       funct3;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;

  logic [1:0]       bht [BHT_DEPTH];
  logic [1:0]       ex_cnt;

  logic             taken;
  logic             is_cond;
  logic             misp_now;

  logic             jump_q;
  logic             misp_q;

  assign if_pc    = bus.if_pc;
  assign ex_pc    = bus.ex_pc;
  assign ex_instr = bus.ex_instr;
  assign opcode   = ex_instr[6:2];
  assign funct3   = ex_instr[14:12];

  // Word-aligned PCs: drop the two byte-offset bits, high bits alias freely.
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Bits of the PC/instruction the predictor intentionally ignores.
  logic unused_bits;
  assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                         ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0],
                         ex_instr[XLEN-1:15], ex_instr[11:7], ex_instr[1:0]};

  // Reads the stored value, so a same-cycle update is only seen next cycle.
  assign bus.if_pred_taken = bht[if_idx][1];
  assign ex_cnt            = bht[ex_idx];

  always_comb begin
    taken   = 1'b0;
    is_cond = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        case (funct3)
          3'b000: begin is_cond = 1'b1; taken =  bus.ex_br_eq; end
          3'b001: begin is_cond = 1'b1; taken = !bus.ex_br_eq; end
          3'b100,
          3'b110: begin is_cond = 1'b1; taken =  bus.ex_br_lt; end
          3'b101,
          3'b111: begin is_cond = 1'b1; taken = !bus.ex_br_lt; end
          default: ;  // 010/011 are not branches: not taken, never train
        endcase
      end
      OP_JAL, OP_JALR: taken = 1'b1;
      default: ;      // everything else resolves not-taken
    endcase
  end

  assign misp_now = taken != bus.ex_pred_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
      jump_q <= 1'b0;
      misp_q <= 1'b0;
    end else begin
      jump_q <= bus.ex_valid & taken;
      misp_q <= bus.ex_valid & misp_now;
      if (bus.ex_valid && is_cond) begin
        if (taken && ex_cnt != 2'b11) begin
          bht[ex_idx] <= ex_cnt + 2'd1;
        end else if (!taken && ex_cnt != 2'b00) begin
          bht[ex_idx] <= ex_cnt - 2'd1;
        end
      end
    end
  end

  assign bus.jump       = jump_q;
  assign bus.mispredict = misp_q;
  assign bus.flush      = misp_q;

`ifdef BPU_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_misp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q   <= '0;
      stat_misp_q <= '0;
    end else if (bus.ex_valid) begin
      if (is_cond && stat_br_q != 32'hFFFF_FFFF) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (misp_now && stat_misp_q != 32'hFFFF_FFFF) begin
        stat_misp_q <= stat_misp_q + 32'd1;
      end
    end
  end

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_misp_q;
`endif

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch/jump decision logic.
- Predicts conditional branches at fetch from a PC-indexed table of 2-bit saturating counters (branch history table, BHT).
- Resolves the actual outcome at execute using the same RV32I opcode/funct3 rules as before, and registers jump/mispredict/flush.
- Trains the table on every resolved conditional branch.
- Sits between the fetch PC mux and the execute stage.

Parameters:
- XLEN, 32, instruction and PC width.
- BHT_DEPTH, 64, number of counters; power of two, at least 2.
- IDX_W, $clog2(BHT_DEPTH), derived table index width; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- if_pc  input  XLEN  fetch PC used for lookup.
- if_pred_taken  output  1  prediction for if_pc; combinational from table.
- ex_valid  input  1  execute stage holds a valid instruction.
- ex_pc  input  XLEN  PC of the execute instruction.
- ex_instr  input  XLEN  execute instruction word.
- ex_br_eq  input  1  rs1 == rs2, from the comparator.
- ex_br_lt  input  1  rs1 < rs2; signedness already selected by the comparator.
- ex_pred_taken  input  1  prediction made for this instruction at fetch.
- jump  output  1  registered: resolved taken.
- mispredict  output  1  registered: resolved outcome differs from ex_pred_taken.
- flush  output  1  registered one-cycle pulse, equal to mispredict.

Behaviour:
- Index: idx = pc[IDX_W+1:2] for both lookup and update. Aliasing is permitted.
- Lookup:
  - if_pred_taken = MSB of counter[idx(if_pc)].
  - Purely combinational; no bypass. A same-cycle update to the same index is not visible until the next cycle.
- Resolve (combinational, internal), decoded from opcode ex_instr[6:2]:
  - 11000 (branch), by funct3 ex_instr[14:12]:
    - 000 BEQ: taken = br_eq.
    - 001 BNE: taken = !br_eq.
    - 100 BLT and 110 BLTU: taken = br_lt.
    - 101 BGE and 111 BGEU: taken = !br_lt.
    - 010 and 011: taken = 0; treated as not-a-branch (no training).
  - 11011 JAL and 11001 JALR: taken = 1.
  - All other opcodes: taken = 0. This deliberately changes the old behaviour, which defaulted to 1.
- Registered outputs, one cycle after the ex_valid cycle:
  - jump = ex_valid & taken.
  - mispredict = ex_valid & (taken != ex_pred_taken).
  - flush = mispredict.
  - With ex_valid = 0, all three are 0 on the next cycle.
- Training, at the clock edge when ex_valid is high and the instruction is a legal conditional branch:
  - Taken: counter[idx(ex_pc)] increments, saturating at 11.
  - Not taken: it decrements, saturating at 00.
  - JAL, JALR and other opcodes never train.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (synchronous, highest priority):
  - All counters go to 01.
  - jump, mispredict and flush go to 0.
  - Training in the reset cycle is suppressed.
  - A resolve in progress at reset is dropped; its outputs never appear.
- Simultaneous lookup and update of the same index: lookup returns the pre-update value.
- Consecutive resolves to the same index on back-to-back cycles: each sees the previous update, with no lost increments.

Optional Feature:
- Macro: BPU_STATS_EN.
- Defined:
  - Adds outputs stat_branches (32) and stat_mispredicts (32).
  - stat_branches increments on every ex_valid legal conditional branch.
  - stat_mispredicts increments on every ex_valid cycle with mispredict, including JAL/JALR.
  - Both saturate at 32'hFFFF_FFFF, clear on rst, and update on the same edge as the registered outputs.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst 1 cycle, then sweep if_pc across all 64 indices -> if_pred_taken = 0 everywhere; jump/mispredict/flush = 0.
- Saturation:
  - Stimulus: ex_pc = 0x100, BEQ with ex_br_eq = 1, ex_pred_taken = 0, 3 cycles.
  - Expected: counter goes 01->10->11->11; if_pc = 0x100 reads 1 after the first update.
  - Expected: mispredict = 1 each cycle, then goes low once ex_pred_taken = 1.
- Funct3 coverage:
  - Each of BEQ/BNE/BLT/BGE/BLTU/BGEU against all four (br_eq, br_lt) combinations, ex_pred_taken = 0 -> jump matches the truth table one cycle later.
  - funct3 010 -> jump = 0, counter unchanged.
- JAL and default opcode:
  - JAL with ex_pred_taken = 0 -> jump = 1, mispredict = 1, flush pulse, counter at its index unchanged.
  - Opcode 01100 (R-type) -> jump = 0.
- Collisions:
  - if_pc = ex_pc = 0x40 with a training update -> if_pred_taken shows the old value that cycle and the new value the next cycle.
  - ex_pc = 0x40 and 0x140 (BHT_DEPTH = 64) -> alias to the same counter.
- Reset mid-operation:
  - Taken branch with ex_valid = 1 and rst = 1 in the same cycle -> next cycle jump = 0, counter = 01.
  - With BPU_STATS_EN defined -> stats = 0.
